// File: rtl/fetch_predict_unit_pkg.sv
// Shared constants and helpers for the fetch/predict stage and its branch target buffer.
// Counter encodings, the default BTB index width and the fetch reset vector live here.
package fetch_predict_unit_pkg;

  localparam logic [1:0] CTR_INIT    = 2'b01;
  localparam logic [1:0] CTR_ALLOC   = 2'b10;
  localparam int         BTB_IDX_BIT = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/fetch_predict_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, synchronous training port.
// Lookup reads pre-update contents; training becomes visible one cycle later.
module branch_target_buffer
  import fetch_predict_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = BTB_IDX_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_hit,
  output logic              rd_taken,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];

  logic [IDX_W-1:0] ridx, uidx;
  logic [TAG_W-1:0] rtag, utag;
  logic             uhit;

  // Byte-offset bits never select an entry.
  logic unused_lsbs;
  assign unused_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

  assign ridx = rd_pc[IDX_W+1:2];
  assign rtag = rd_pc[ADDR_W-1:IDX_W+2];
  assign uidx = upd_pc[IDX_W+1:2];
  assign utag = upd_pc[ADDR_W-1:IDX_W+2];

  assign rd_hit    = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign rd_taken  = rd_hit && ctr_q[ridx][1];
  assign rd_target = tgt_q[ridx];
  assign uhit      = valid_q[uidx] && (tag_q[uidx] == utag);

  // NOTE: every _d gets a full default copy first, so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_en) begin
      if (uhit) begin
        if (upd_taken) begin
          ctr_d[uidx] = sat_inc(ctr_q[uidx]);
          tgt_d[uidx] = upd_target;
        end else begin
          ctr_d[uidx] = sat_dec(ctr_q[uidx]);
        end
      end else if (upd_taken) begin
        valid_d[uidx] = 1'b1;
        tag_d[uidx]   = utag;
        tgt_d[uidx]   = upd_target;
        ctr_d[uidx]   = CTR_ALLOC;
      end
    end
  end

  // NOTE: only valid bits and counters are reset; tag/target contents are don't-care while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// Instruction-fetch stage: owns the PC, queries the BTB each cycle and picks the next fetch address.
// Priority at each edge: halt (en=0), EX redirect, load-use stall, predicted next_pc.
module fetch_predict_unit
  import fetch_predict_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              IDX_W    = BTB_IDX_BIT,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_4,
  output logic              gussed,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] btb_target;
  logic              btb_hit;

  branch_target_buffer #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_pc      (pc_q),
    .rd_hit     (btb_hit),
    .rd_taken   (gussed),
    .rd_target  (btb_target),
    .upd_en     (en && upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  assign pc      = pc_q;
  assign pc_4    = pc_q + ADDR_W'(4);
  assign next_pc = gussed ? btb_target : pc_4;

  logic unused_hit;
  assign unused_hit = btb_hit;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      if (redirect)    pc_d = redirect_pc;
      else if (!stall) pc_d = next_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit: expectations are queued as stimulus is applied
// and popped against DUT outputs one time unit after each active edge.
module tb_fetch_predict_unit;

  typedef enum logic [1:0] {SIG_PC, SIG_PC4, SIG_G, SIG_NPC} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, stall, redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] pc, pc_4, next_pc;
  logic        gussed;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  fetch_predict_unit #(.ADDR_W(32), .IDX_W(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc), .pc_4(pc_4), .gussed(gussed), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        SIG_PC:  obs = pc;
        SIG_PC4: obs = pc_4;
        SIG_G:   obs = {31'b0, gussed};
        default: obs = next_pc;
      endcase
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic upd(input logic v, input logic [31:0] a, input logic t, input logic [31:0] tgt);
    upd_valid = v; upd_pc = a; upd_taken = t; upd_target = tgt;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    step(2);
    rst = 1'b0;
    expect_val("reset_pc", SIG_PC, 32'h0);
    expect_val("reset_pc4", SIG_PC4, 32'h4);
    expect_val("reset_gussed", SIG_G, 32'h0);
    check_all();

    // Free-run to 0x40, then pulse reset asynchronously.
    step(16);
    expect_val("run_to_40", SIG_PC, 32'h40);
    check_all();
    #1 rst = 1'b1;
    #1;
    expect_val("async_rst_pc", SIG_PC, 32'h0);
    expect_val("async_rst_pc4", SIG_PC4, 32'h4);
    expect_val("async_rst_gussed", SIG_G, 32'h0);
    check_all();
    rst = 1'b0;
    step(1); expect_val("post_rst_4", SIG_PC, 32'h4); check_all();
    step(1); expect_val("post_rst_8", SIG_PC, 32'h8); check_all();
    step(1); expect_val("post_rst_c", SIG_PC, 32'hC); check_all();

    // Allocate 0x10 -> 0x80 while fetching 0xC; the prediction is live at 0x10.
    upd(1'b1, 32'h10, 1'b1, 32'h80);
    step(1);
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    expect_val("alloc_pc", SIG_PC, 32'h10);
    expect_val("alloc_gussed", SIG_G, 32'h1);
    expect_val("alloc_next", SIG_NPC, 32'h80);
    check_all();
    step(1);
    expect_val("alloc_jump", SIG_PC, 32'h80);
    check_all();

    // Counter: 10 -> 11 (saturates over four taken) -> 10 via one not-taken, under stall.
    stall = 1'b1;
    upd(1'b1, 32'h10, 1'b1, 32'h80);
    step(4);
    expect_val("stall_hold_80", SIG_PC, 32'h80);
    check_all();
    upd(1'b1, 32'h10, 1'b0, 32'h0);
    step(1);
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h10;
    step(1);
    redirect = 1'b0;
    expect_val("redir_over_stall", SIG_PC, 32'h10);
    expect_val("ctr10_gussed", SIG_G, 32'h1);
    expect_val("ctr10_next", SIG_NPC, 32'h80);
    check_all();
    upd(1'b1, 32'h10, 1'b0, 32'h0);
    step(1);
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    expect_val("ctr01_pc_held", SIG_PC, 32'h10);
    expect_val("ctr01_gussed", SIG_G, 32'h0);
    expect_val("ctr01_next", SIG_NPC, 32'h14);
    check_all();

    // Priority: redirect beats stall, stall holds, en=0 freezes pc and BTB.
    redirect = 1'b1; redirect_pc = 32'h200;
    step(1);
    redirect = 1'b0;
    expect_val("prio_redirect", SIG_PC, 32'h200);
    check_all();
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_val("prio_stall", SIG_PC, 32'h200);
      check_all();
    end
    stall = 1'b0; en = 1'b0;
    upd(1'b1, 32'h10, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_val("halt_pc", SIG_PC, 32'h200);
      check_all();
    end
    en = 1'b1;
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
    step(1);
    redirect = 1'b0;
    expect_val("halt_btb_frozen", SIG_G, 32'h0);
    check_all();

    // Aliasing with read-before-write: 0x50 shares index 4 with 0x10.
    upd(1'b1, 32'h10, 1'b1, 32'h80);
    step(1);
    upd(1'b1, 32'h50, 1'b1, 32'h300);
    #1;
    expect_val("rbw_old_gussed", SIG_G, 32'h1);
    expect_val("rbw_old_next", SIG_NPC, 32'h80);
    check_all();
    step(1);
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    expect_val("alias_miss_gussed", SIG_G, 32'h0);
    expect_val("alias_miss_next", SIG_NPC, 32'h14);
    check_all();
    redirect = 1'b1; redirect_pc = 32'h50;
    step(1);
    redirect = 1'b0;
    expect_val("alias_new_gussed", SIG_G, 32'h1);
    expect_val("alias_new_next", SIG_NPC, 32'h300);
    check_all();

    // Wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect = 1'b0; stall = 1'b0;
    expect_val("wrap_pc4", SIG_PC4, 32'h0);
    expect_val("wrap_next", SIG_NPC, 32'h0);
    check_all();
    step(1);
    expect_val("wrap_pc", SIG_PC, 32'h0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
